pipelined_adder: RTL and testbench

//   Parametrised, pipelined add/subtract unit; successor to the flat 16-bit combinational adder.

---
 rtl/pipelined_adder.sv | 87 ++++++++
 tb/tb_pipelined_adder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// pipelined_adder: add/subtract unit whose carry chain is cut into STAGES registered slices,
// valid/ready on both sides, reporting carry-out and signed overflow.
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CW  = WIDTH / STAGES;
  localparam int CW1 = CW + 1;

  if (STAGES < 1 || STAGES > WIDTH || WIDTH % STAGES != 0) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
  end

  logic              adv;
  logic [STAGES-1:0] v_q, v_in;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic              c_q [STAGES];
  logic [WIDTH-1:0]  a_in [STAGES];
  logic [WIDTH-1:0]  b_in [STAGES];
  logic [WIDTH-1:0]  s_in [STAGES];
  logic              c_in [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];
  logic [CW:0]       r_d [STAGES];

  // Stage k adds slice k of the operands it carries, so each register level closes one CW-bit chain.
  always_comb begin
    adv     = !v_q[STAGES-1] | out_ready;
    v_in[0] = in_valid;
    a_in[0] = data_a;
    b_in[0] = sub ? ~data_b : data_b;
    c_in[0] = sub;
    s_in[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      v_in[k] = v_q[k-1];
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      c_in[k] = c_q[k-1];
      s_in[k] = s_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      r_d[k] = {1'b0, a_in[k][k*CW +: CW]} + {1'b0, b_in[k][k*CW +: CW]} + CW1'(c_in[k]);
      s_d[k] = s_in[k];
      s_d[k][k*CW +: CW] = r_d[k][CW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
    end else if (adv) begin
      v_q <= v_in;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_in[k];
        b_q[k] <= b_in[k];
        s_q[k] <= s_d[k];
        c_q[k] <= r_d[k][CW];
      end
    end
  end

  assign in_ready  = adv;
  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1]) & (sum[WIDTH-1] != a_q[STAGES-1][WIDTH-1]);
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed checks on a 2-stage unit plus random scoreboard runs at 1, 4 and 16 stages.
module tb_pipelined_adder;
  logic        clk, rst_n, in_valid, in_ready, sub, out_valid, out_ready, cout, ovf, go;
  logic [15:0] data_a, data_b, sum;
  logic [17:0] q_d[$];
  int          vectors = 0, miscompares = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  pipelined_adder #(.WIDTH(16), .STAGES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .data_a(data_a), .data_b(data_b), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: true integer add/subtract, then wrap, unsigned carry and signed range test.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
    int ru, rs;
    logic c;
    ru = s ? int'(a) - int'(b) : int'(a) + int'(b);
    rs = s ? int'($signed(a)) - int'($signed(b)) : int'($signed(a)) + int'($signed(b));
    c  = s ? (a >= b) : (ru > 65535);
    return {ru[15:0], c, (rs > 32767) || (rs < -32768)};
  endfunction

  function automatic logic [15:0] pick();
    logic [15:0] corner [4] = '{16'hFFFF, 16'h8000, 16'h7FFF, 16'h0000};
    return ($urandom_range(3) == 0) ? corner[$urandom_range(3)] : 16'($urandom);
  endfunction

  // Directed driver: called at posedge+1, returns at posedge+1 of the accepting edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic s, input logic [17:0] e);
    in_valid = 1; data_a = a; data_b = b; sub = s;
    for (int t = 0; t <= 50; t++) begin
      @(negedge clk);
      if (in_ready) begin
        q_d.push_back(e);
        break;
      end
      if (t == 50) chk("send_timeout", 32'(in_ready), 32'd1);
    end
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  always @(negedge clk)
    if (rst_n && out_valid && out_ready) begin
      if (q_d.size() == 0) chk("dir_unexpected_out", 32'(out_valid), 32'd0);
      else chk("dir_result", 32'({sum, cout, ovf}), 32'(q_d.pop_front()));
    end

  for (genvar g = 0; g < 3; g++) begin : gr
    localparam int ST = (g == 0) ? 1 : (g == 1) ? 4 : 16;
    logic        iv, ir, ov, orr, s, co, of, done;
    logic [15:0] a, b, sm;
    logic [17:0] q[$];

    pipelined_adder #(.WIDTH(16), .STAGES(ST)) u_rnd (
      .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir),
      .data_a(a), .data_b(b), .sub(s), .out_valid(ov),
      .out_ready(orr), .sum(sm), .cout(co), .ovf(of)
    );

    initial begin
      int n;
      iv = 0; orr = 1; a = 0; b = 0; s = 0; done = 0; n = 0;
      wait (go);
      @(posedge clk); #1;
      for (int cyc = 0; n < 1000 && cyc < 20000; cyc++) begin
        iv  = $urandom_range(3) != 0;
        a   = pick();
        b   = pick();
        s   = 1'($urandom_range(1));
        orr = $urandom_range(3) != 0;
        @(negedge clk);
        if (iv && ir) begin
          q.push_back(model(a, b, s));
          n++;
        end
        @(posedge clk); #1;
      end
      chk($sformatf("t6_s%0d_ops", ST), 32'(n), 32'd1000);
      iv = 0; orr = 1;
      for (int t = 0; t < 100 && q.size() != 0; t++) @(posedge clk);
      #1 chk($sformatf("t6_s%0d_drain", ST), 32'(q.size()), 32'd0);
      done = 1;
    end

    always @(negedge clk)
      if (rst_n && ov && orr) begin
        if (q.size() == 0) chk($sformatf("t6_s%0d_unexpected_out", ST), 32'(ov), 32'd0);
        else chk($sformatf("t6_s%0d_result", ST), 32'({sm, co, of}), 32'(q.pop_front()));
      end
  end

  initial begin
    logic [15:0] ta [4] = '{16'h1000, 16'hF00F, 16'h4321, 16'h8001};
    logic [15:0] tb [4] = '{16'h0F01, 16'h1FF1, 16'h5432, 16'h0002};
    logic [17:0] e0;
    rst_n = 1; in_valid = 0; out_ready = 1; data_a = 0; data_b = 0; sub = 0; go = 0;
    #2 rst_n = 0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout_ovf", 32'({cout, ovf}), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    @(negedge clk) chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    // T1: exact two-cycle latency
    send(16'h1234, 16'h0FFF, 0, {16'h2233, 1'b0, 1'b0});
    @(negedge clk) chk("t1_lat_cycle1", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("t1_lat_cycle2", 32'(out_valid), 32'd1);
    chk("t1_sum", 32'(sum), 32'h2233);
    @(posedge clk); #1;
    // T2/T3: slice-boundary carries, borrow and signed overflow, back to back
    send(16'h00FF, 16'h0001, 0, {16'h0100, 1'b0, 1'b0});
    send(16'hFFFF, 16'h0001, 0, {16'h0000, 1'b1, 1'b0});
    send(16'h0005, 16'h0007, 1, {16'hFFFE, 1'b0, 1'b0});
    send(16'h7FFF, 16'h0001, 0, {16'h8000, 1'b0, 1'b1});
    send(16'h8000, 16'h0001, 1, {16'h7FFF, 1'b1, 1'b1});
    repeat (4) @(posedge clk);
    #1;
    // T4: back-pressure with four ops
    e0 = model(ta[0], tb[0], 0);
    out_ready = 0;
    fork
      for (int i = 0; i < 4; i++) send(ta[i], tb[i], i[0], model(ta[i], tb[i], i[0]));
      begin
        repeat (3) @(negedge clk);
        chk("t4_in_ready_full", 32'(in_ready), 32'd0);
        chk("t4_out_valid_held", 32'(out_valid), 32'd1);
        chk("t4_sum_held", 32'(sum), 32'(e0[17:2]));
        repeat (2) @(negedge clk);
        chk("t4_sum_still_held", 32'({sum, cout, ovf}), 32'(e0));
        chk("t4_in_ready_still_0", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          chk($sformatf("t4_stream_%0d", i), 32'(out_valid), 32'd1);
        end
      end
    join
    @(negedge clk) chk("t4_empty", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    // T5: asynchronous reset with two ops in flight
    send(16'h1111, 16'h2222, 0, model(16'h1111, 16'h2222, 0));
    send(16'h3333, 16'h0444, 1, model(16'h3333, 16'h0444, 1));
    #2 rst_n = 0;
    #1;
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    chk("t5_sum", 32'(sum), 32'd0);
    chk("t5_in_ready", 32'(in_ready), 32'd1);
    q_d.delete();
    #3 rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("t5_no_stale_%0d", i), 32'(out_valid), 32'd0);
    end
    // T6: random regressions on the other depths
    go = 1;
    for (int t = 0; t < 30000 && !(gr[0].done && gr[1].done && gr[2].done); t++) @(posedge clk);
    chk("t6_all_done", 32'(gr[0].done && gr[1].done && gr[2].done), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
